// File: rtl/frame_diff_scan_ctrl.sv
// Read-side sequencer for the ping-pong frame store: on each frame swap it rasters the read port
// and streams |curr-prev| with a motion flag, then publishes the per-frame motion-pixel count.
module frame_diff_scan_ctrl #(
   parameter int unsigned WIDTH  = 160,
   parameter int unsigned HEIGHT = 120,
   parameter int unsigned DEPTH  = WIDTH * HEIGHT,
   parameter int unsigned ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              buffer_sel,
   input  logic [7:0]        threshold,
   output logic              fb_oe,
   output logic [ADDR_W-1:0] fb_rAddr,
   input  logic [7:0]        curr_data,
   input  logic [7:0]        prev_data,
   output logic              pix_valid,
   output logic [7:0]        pix_x,
   output logic [6:0]        pix_y,
   output logic [7:0]        pix_diff,
   output logic              pix_motion,
   output logic              scan_busy,
   output logic              scan_done,
   output logic              scan_abort,
   output logic [14:0]       motion_count
);

   localparam int unsigned PIX_W = 8;
   localparam int unsigned X_W   = 8;
   localparam int unsigned Y_W   = 7;
   localparam int unsigned CNT_W = 15;
   localparam int unsigned SWP_W = 2;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [X_W-1:0]    LAST_X    = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(HEIGHT - 1);
   localparam logic [SWP_W-1:0]  SWAP_FULL = SWP_W'(2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state_q, state_nxt;
   logic               sel_q;
   logic [SWP_W-1:0]   swap_cnt_q, swap_cnt_nxt;
   logic [ADDR_W-1:0]  addr_q, addr_nxt;
   logic [X_W-1:0]     x_q, x_nxt;
   logic [Y_W-1:0]     y_q, y_nxt;
   logic [PIX_W-1:0]   thr_q, thr_nxt;
   logic               drain_q, drain_nxt;
   logic [CNT_W-1:0]   run_cnt_q, run_nxt;

   logic               fb_oe_nxt;
   logic [ADDR_W-1:0]  fb_addr_nxt;
   logic [X_W-1:0]     iss_x_q, iss_x_nxt;
   logic [Y_W-1:0]     iss_y_q, iss_y_nxt;
   logic               done_nxt;
   logic               abort_nxt;

   logic               d1_v_q;
   logic [X_W-1:0]     d1_x_q;
   logic [Y_W-1:0]     d1_y_q;

   logic               swap_c;
   logic               load_c;
   logic               flush_c;
   logic               commit_c;
   logic               pix_take_c;
   logic [PIX_W-1:0]   diff_c;
   logic               motion_c;

   assign swap_c = buffer_sel ^ sel_q;

   // Sequencer: start/restart/abort decisions and read-address generation
   always_comb begin
      state_nxt    = state_q;
      swap_cnt_nxt = swap_cnt_q;
      addr_nxt     = addr_q;
      x_nxt        = x_q;
      y_nxt        = y_q;
      thr_nxt      = thr_q;
      drain_nxt    = drain_q;
      fb_oe_nxt    = 1'b0;
      fb_addr_nxt  = fb_rAddr;
      iss_x_nxt    = iss_x_q;
      iss_y_nxt    = iss_y_q;
      done_nxt     = 1'b0;
      abort_nxt    = 1'b0;
      load_c       = 1'b0;
      flush_c      = 1'b0;
      commit_c     = 1'b0;

      if (swap_c && (swap_cnt_q != SWAP_FULL)) begin
         swap_cnt_nxt = swap_cnt_q + SWP_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (swap_c && enable && (swap_cnt_nxt == SWAP_FULL)) begin
               state_nxt = SCAN;
               load_c    = 1'b1;
            end
         end
         SCAN, DRAIN: begin
            if (!enable) begin
               state_nxt = IDLE;
               abort_nxt = 1'b1;
               flush_c   = 1'b1;
            end else if (swap_c) begin
               state_nxt = SCAN;
               abort_nxt = 1'b1;
               flush_c   = 1'b1;
               load_c    = 1'b1;
            end else if (state_q == SCAN) begin
               fb_oe_nxt   = 1'b1;
               fb_addr_nxt = addr_q;
               iss_x_nxt   = x_q;
               iss_y_nxt   = y_q;
               addr_nxt    = addr_q + ADDR_W'(1);
               if (x_q == LAST_X) begin
                  x_nxt = '0;
                  y_nxt = (y_q == LAST_Y) ? '0 : y_q + Y_W'(1);
               end else begin
                  x_nxt = x_q + X_W'(1);
               end
               if (addr_q == LAST_ADDR) begin
                  state_nxt = DRAIN;
                  drain_nxt = 1'b0;
               end
            end else if (drain_q) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               commit_c  = 1'b1;
            end else begin
               drain_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (load_c) begin
         addr_nxt = '0;
         x_nxt    = '0;
         y_nxt    = '0;
         thr_nxt  = threshold;
      end
   end

   // Difference datapath; a flush drops whatever is still in the read pipeline
   always_comb begin
      diff_c     = (curr_data >= prev_data) ? (curr_data - prev_data) : (prev_data - curr_data);
      motion_c   = diff_c > thr_q;
      pix_take_c = d1_v_q && !flush_c;
      run_nxt    = run_cnt_q;
      if (load_c) begin
         run_nxt = '0;
      end else if (pix_take_c) begin
         run_nxt = run_cnt_q + CNT_W'(motion_c);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         sel_q        <= buffer_sel;
         swap_cnt_q   <= '0;
         addr_q       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         thr_q        <= '0;
         drain_q      <= 1'b0;
         run_cnt_q    <= '0;
         iss_x_q      <= '0;
         iss_y_q      <= '0;
         d1_v_q       <= 1'b0;
         d1_x_q       <= '0;
         d1_y_q       <= '0;
         fb_oe        <= 1'b0;
         fb_rAddr     <= '0;
         pix_valid    <= 1'b0;
         pix_x        <= '0;
         pix_y        <= '0;
         pix_diff     <= '0;
         pix_motion   <= 1'b0;
         scan_busy    <= 1'b0;
         scan_done    <= 1'b0;
         scan_abort   <= 1'b0;
         motion_count <= '0;
      end else begin
         state_q    <= state_nxt;
         sel_q      <= buffer_sel;
         swap_cnt_q <= swap_cnt_nxt;
         addr_q     <= addr_nxt;
         x_q        <= x_nxt;
         y_q        <= y_nxt;
         thr_q      <= thr_nxt;
         drain_q    <= drain_nxt;
         run_cnt_q  <= run_nxt;
         iss_x_q    <= iss_x_nxt;
         iss_y_q    <= iss_y_nxt;
         d1_v_q     <= fb_oe && !flush_c;
         d1_x_q     <= iss_x_q;
         d1_y_q     <= iss_y_q;
         fb_oe      <= fb_oe_nxt;
         fb_rAddr   <= fb_addr_nxt;
         pix_valid  <= pix_take_c;
         if (pix_take_c) begin
            pix_x      <= d1_x_q;
            pix_y      <= d1_y_q;
            pix_diff   <= diff_c;
            pix_motion <= motion_c;
         end
         scan_busy  <= state_nxt != IDLE;
         scan_done  <= done_nxt;
         scan_abort <= abort_nxt;
         if (commit_c) begin
            motion_count <= run_nxt;
         end
      end
   end

endmodule

// File: tb/tb_frame_diff_scan_ctrl.sv
// Bench for frame_diff_scan_ctrl: a frame-store memory model feeds the DUT and every streamed
// pixel and per-frame count is compared against values computed directly from the memory contents.
module tb_frame_diff_scan_ctrl;

   localparam int WIDTH  = 160;
   localparam int HEIGHT = 120;
   localparam int DEPTH  = WIDTH * HEIGHT;
   localparam int ADDR_W = 15;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              enable;
   logic              buffer_sel;
   logic [7:0]        threshold;
   logic              fb_oe;
   logic [ADDR_W-1:0] fb_rAddr;
   logic [7:0]        curr_data = '0;
   logic [7:0]        prev_data = '0;
   logic              pix_valid;
   logic [7:0]        pix_x;
   logic [6:0]        pix_y;
   logic [7:0]        pix_diff;
   logic              pix_motion;
   logic              scan_busy;
   logic              scan_done;
   logic              scan_abort;
   logic [14:0]       motion_count;

   logic [7:0] curr_mem [DEPTH];
   logic [7:0] prev_mem [DEPTH];

   int n_cmp = 0;
   int n_bad = 0;

   int cyc, idx, nvalid, pix_bad, gaps, last_valid_cyc;
   int ndone, done_cyc, nabort, n_oe, exp_addr, addr_bad, last_oe_cyc;
   logic [7:0]  mthr;
   logic [7:0]  first_diff;
   logic [14:0] w_a, w_b, w_last;
   logic [14:0] saved_cnt;

   frame_diff_scan_ctrl #(
      .WIDTH  (160),
      .HEIGHT (120),
      .DEPTH  (19200),
      .ADDR_W (15)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .buffer_sel   (buffer_sel),
      .threshold    (threshold),
      .fb_oe        (fb_oe),
      .fb_rAddr     (fb_rAddr),
      .curr_data    (curr_data),
      .prev_data    (prev_data),
      .pix_valid    (pix_valid),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_diff     (pix_diff),
      .pix_motion   (pix_motion),
      .scan_busy    (scan_busy),
      .scan_done    (scan_done),
      .scan_abort   (scan_abort),
      .motion_count (motion_count)
   );

   always #5 clk = ~clk;

   // Frame store: registered read, data one clock after the read enable
   always @(posedge clk) begin
      if (fb_oe && (int'(fb_rAddr) < DEPTH)) begin
         curr_data <= curr_mem[fb_rAddr];
         prev_data <= prev_mem[fb_rAddr];
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int exp_diff(input int k);
      int c, p;
      c = int'(curr_mem[k]);
      p = int'(prev_mem[k]);
      return (c > p) ? c - p : p - c;
   endfunction

   function automatic int model_count(input logic [7:0] t);
      int n = 0;
      for (int k = 0; k < DEPTH; k++) begin
         if (exp_diff(k) > int'(t)) n++;
      end
      return n;
   endfunction

   task automatic clr_obs();
      idx = 0; nvalid = 0; pix_bad = 0; gaps = 0; last_valid_cyc = 0;
      ndone = 0; done_cyc = 0; nabort = 0; n_oe = 0; exp_addr = 0;
      addr_bad = 0; last_oe_cyc = 0;
   endtask

   task automatic observe();
      int ed;
      if (pix_valid) begin
         if (nvalid > 0 && cyc != last_valid_cyc + 1) gaps++;
         last_valid_cyc = cyc;
         if (idx >= DEPTH) begin
            pix_bad++;
         end else begin
            ed = exp_diff(idx);
            if (pix_x != 8'(idx % WIDTH) || pix_y != 7'(idx / WIDTH) ||
                pix_diff != 8'(ed) || pix_motion != (ed > int'(mthr)))
               pix_bad++;
         end
         if (idx == 0)         first_diff = pix_diff;
         if (idx == WIDTH - 1) w_a = {pix_x, pix_y};
         if (idx == WIDTH)     w_b = {pix_x, pix_y};
         if (idx == DEPTH - 1) w_last = {pix_x, pix_y};
         idx++;
         nvalid++;
      end
      if (fb_oe) begin
         if (int'(fb_rAddr) != exp_addr) addr_bad++;
         exp_addr++;
         n_oe++;
         last_oe_cyc = cyc;
      end
      if (scan_done) begin
         ndone++;
         done_cyc = cyc;
      end
      if (scan_abort) nabort++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      observe();
   endtask

   task automatic start_scan(input logic [7:0] t);
      threshold  = t;
      mthr       = t;
      clr_obs();
      buffer_sel = ~buffer_sel;
   endtask

   task automatic wait_addr(input string tag, input int a, input int budget);
      int n = 0;
      while (!(fb_oe === 1'b1 && int'(fb_rAddr) == a) && n < budget) begin
         tick();
         n++;
      end
      check(tag, {fb_oe, fb_rAddr}, {1'b1, 15'(a)});
   endtask

   task automatic run_to_end(input string tag, input int budget);
      int n = 0;
      while (ndone == 0 && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_done"},   ndone, 1);
      check({tag, "_nvalid"}, nvalid, DEPTH);
      check({tag, "_pix"},    pix_bad, 0);
      check({tag, "_gaps"},   gaps, 0);
      check({tag, "_addr"},   addr_bad, 0);
      check({tag, "_noe"},    n_oe, DEPTH);
      check({tag, "_lat"},    done_cyc - last_oe_cyc, 2);
      check({tag, "_count"},  motion_count, model_count(mthr));
      check({tag, "_busy"},   scan_busy, 0);
      tick();
      check({tag, "_pulse"},  scan_done, 0);
   endtask

   task automatic fill_const(input logic [7:0] c, input logic [7:0] p);
      for (int k = 0; k < DEPTH; k++) begin
         curr_mem[k] = c;
         prev_mem[k] = p;
      end
   endtask

   // Mixes curr<prev, diff exactly at threshold, diff just above it, and random pixels
   task automatic fill_mix(input logic [7:0] t);
      for (int k = 0; k < DEPTH; k++) begin
         case (k % 5)
            0: begin curr_mem[k] = 8'h05;          prev_mem[k] = 8'hF0;           end
            1: begin curr_mem[k] = 8'h10 + t;      prev_mem[k] = 8'h10;           end
            2: begin curr_mem[k] = 8'h10;          prev_mem[k] = 8'h11 + t;       end
            default: begin curr_mem[k] = 8'($urandom); prev_mem[k] = 8'($urandom); end
         endcase
      end
   endtask

   initial begin
      logic [7:0] thr_mix;
      cyc = 0;
      clr_obs();
      mthr = '0; first_diff = '0; w_a = '0; w_b = '0; w_last = '0;
      reset_n = 1'b0; enable = 1'b0; buffer_sel = 1'b0; threshold = '0;
      fill_const(8'h40, 8'h40);
      repeat (3) tick();
      check("rst_fb",    {fb_oe, fb_rAddr}, '0);
      check("rst_pix",   {pix_valid, pix_x, pix_y, pix_diff, pix_motion}, '0);
      check("rst_flags", {scan_busy, scan_done, scan_abort}, '0);
      check("rst_count", motion_count, 0);

      // One swap after reset is not enough to start
      reset_n = 1'b1; enable = 1'b1;
      tick();
      clr_obs();
      buffer_sel = ~buffer_sel;
      repeat (8) tick();
      check("warm1_oe",   n_oe, 0);
      check("warm1_busy", scan_busy, 0);

      // Second swap starts; first read one clock after entering the scan
      start_scan(8'($urandom));
      tick();
      check("start_oe0",  fb_oe, 0);
      check("start_busy", scan_busy, 1);
      tick();
      check("start_oe1",  fb_oe, 1);
      check("start_addr", fb_rAddr, 0);
      run_to_end("eq", 19300);
      check("eq_diff0", first_diff, 8'h00);

      // Mixed pattern; threshold input changes mid-scan and must be ignored
      thr_mix = 8'($urandom_range(32, 192));
      fill_mix(thr_mix);
      start_scan(thr_mix);
      repeat (3000) tick();
      threshold = 8'($urandom);
      run_to_end("mix", 17000);
      check("mix_diff0", first_diff, 8'hEB);
      check("mix_x159",  w_a, {8'd159, 7'd0});
      check("mix_x160",  w_b, {8'd0, 7'd1});
      check("mix_last",  w_last, {8'd159, 7'd119});
      saved_cnt = motion_count;

      // Swap mid-scan: abort, hold count, restart from 0 with the new threshold
      fill_const(8'h50, 8'h40);
      start_scan(8'h10);
      wait_addr("ab_reach", 5000, 6000);
      check("ab_pre_nvalid", nvalid, 4999);
      check("ab_pre_pix",    pix_bad, 0);
      start_scan(8'h0F);
      tick();
      check("ab_pulse", scan_abort, 1);
      check("ab_hold",  motion_count, saved_cnt);
      check("ab_oe",    fb_oe, 0);
      check("ab_pv",    pix_valid, 0);
      tick();
      check("ab_pulse_end",  scan_abort, 0);
      check("ab_restart",    {fb_oe, fb_rAddr}, {1'b1, 15'd0});
      run_to_end("rs", 19300);
      check("rs_diff0",  first_diff, 8'h10);
      check("rs_nabort", nabort, 1);

      // Reset mid-scan clears everything, including the swap warm-up
      start_scan(8'h30);
      wait_addr("rm_reach", 300, 400);
      reset_n = 1'b0;
      tick();
      check("rm_fb",    {fb_oe, fb_rAddr}, '0);
      check("rm_pix",   {pix_valid, pix_x, pix_y, pix_diff, pix_motion}, '0);
      check("rm_flags", {scan_busy, scan_done, scan_abort}, '0);
      check("rm_count", motion_count, 0);
      reset_n = 1'b1;
      tick();
      clr_obs();
      buffer_sel = ~buffer_sel;
      repeat (10) tick();
      check("rw1_oe", n_oe, 0);

      // Swap with enable low only counts; enable rising with a swap starts
      enable = 1'b0;
      buffer_sel = ~buffer_sel;
      repeat (10) tick();
      check("dis_oe", n_oe, 0);
      enable = 1'b1;
      start_scan(8'h30);
      wait_addr("en_reach", 100, 300);
      check("en_addr", addr_bad, 0);
      check("en_pix",  pix_bad, 0);

      // Enable drop mid-scan
      saved_cnt = motion_count;
      enable = 1'b0;
      clr_obs();
      tick();
      check("ed_pulse", scan_abort, 1);
      check("ed_oe",    fb_oe, 0);
      check("ed_busy",  scan_busy, 0);
      repeat (20) tick();
      check("ed_nvalid", nvalid, 0);
      check("ed_ndone",  ndone, 0);
      check("ed_noe",    n_oe, 0);
      check("ed_nabort", nabort, 1);
      check("ed_count",  motion_count, saved_cnt);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
